// File: rtl/scroll_ctrl.sv
// Scrolling-message sequencer: fetches message columns, strobes them into a column
// shifter, requests a frame update per shift and paces shifts by a programmable period.
module scroll_ctrl #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic [7:0]          msg_len,
    input  logic [PERIOD_W-1:0] period,
    input  logic                loop,
    output logic                col_req,
    output logic [7:0]          col_addr,
    input  logic                col_vld,
    input  logic [7:0]          col_data,
    output logic                sh_en,
    output logic                sh_dir,
    output logic [7:0]          sh_d,
    output logic                upd_req,
    input  logic                upd_ack,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, UPDATE, WAIT} state_t;

    state_t              state;
    logic [7:0]          len_q;
    logic [7:0]          idx;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] timer;
    logic                loop_q;
    logic                tail;
    logic [2:0]          tail_cnt;

    // A period of 0 is treated as 1, so WAIT always lasts at least one cycle.
    function automatic logic [PERIOD_W-1:0] wait_load(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            idx      <= '0;
            period_q <= '0;
            timer    <= '0;
            loop_q   <= 1'b0;
            tail     <= 1'b0;
            tail_cnt <= '0;
            col_req  <= 1'b0;
            col_addr <= '0;
            sh_en    <= 1'b0;
            sh_dir   <= 1'b0;
            sh_d     <= '0;
            upd_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sh_en <= 1'b0;
            done  <= 1'b0;
            if (stop && state != IDLE) begin
                state    <= IDLE;
                col_req  <= 1'b0;
                col_addr <= '0;
                upd_req  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            if (msg_len == '0) begin
                                done <= 1'b1;
                            end else begin
                                len_q    <= msg_len;
                                period_q <= period;
                                loop_q   <= loop;
                                sh_dir   <= dir;
                                idx      <= '0;
                                tail     <= 1'b0;
                                tail_cnt <= '0;
                                col_req  <= 1'b1;
                                col_addr <= '0;
                                busy     <= 1'b1;
                                state    <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        // Blank-tail columns need no fetch handshake.
                        if (tail) begin
                            sh_d  <= '0;
                            sh_en <= 1'b1;
                            state <= SHIFT;
                        end else if (col_vld) begin
                            sh_d     <= col_data;
                            col_req  <= 1'b0;
                            col_addr <= '0;
                            sh_en    <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        upd_req <= 1'b1;
                        state   <= UPDATE;
                    end
                    UPDATE: begin
                        if (upd_ack) begin
                            upd_req <= 1'b0;
                            timer   <= wait_load(period_q);
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else if (!tail) begin
                            state <= FETCH;
                            if (idx == len_q - 8'd1) begin
                                tail     <= 1'b1;
                                tail_cnt <= '0;
                            end else begin
                                idx      <= idx + 8'd1;
                                col_req  <= 1'b1;
                                col_addr <= idx + 8'd1;
                            end
                        end else if (tail_cnt == 3'd7) begin
                            if (loop_q) begin
                                tail     <= 1'b0;
                                idx      <= '0;
                                col_req  <= 1'b1;
                                col_addr <= '0;
                                state    <= FETCH;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            tail_cnt <= tail_cnt + 3'd1;
                            state    <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
